// File: rtl/dino_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dino_input_ctrl
// Description : Button synchronizer/debouncer with frame-aligned jump requests,
//               frame-coherent duck level and debug event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module dino_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20,
   parameter int HOLD_FRAMES     = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       screen_end,
   input  logic       io_ack,
   output logic       io_jump,
   output logic       io_duck,
   output logic [7:0] jump_count,
   output logic [7:0] drop_count
);

   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam int               c_hold_w   = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
   localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_FRAMES - 1);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   logic             r_up_s1, r_up_s2, r_up_db;
   logic [CNT_W-1:0] r_up_cnt;
   logic             r_dn_s1, r_dn_s2, r_dn_db;
   logic [CNT_W-1:0] r_dn_cnt;

   logic                r_press;
   logic                r_pending;
   logic [c_hold_w-1:0] r_hold;
   state_t              r_state;

   logic w_up_flip, w_dn_flip, w_up_press;

   // A flip happens on the edge where the counter has seen a full window of disagreement.
   assign w_up_flip  = (r_up_s2 != r_up_db) && (r_up_cnt == c_cnt_last);
   assign w_dn_flip  = (r_dn_s2 != r_dn_db) && (r_dn_cnt == c_cnt_last);
   assign w_up_press = w_up_flip & r_up_s2;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_up_s1  <= 1'b0;
         r_up_s2  <= 1'b0;
         r_up_db  <= 1'b0;
         r_up_cnt <= '0;
      end else begin
         r_up_s1 <= btn_up;
         r_up_s2 <= r_up_s1;
         if (r_up_s2 == r_up_db) begin
            r_up_cnt <= '0;
         end else if (w_up_flip) begin
            r_up_db  <= r_up_s2;
            r_up_cnt <= '0;
         end else begin
            r_up_cnt <= r_up_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_dn_s1  <= 1'b0;
         r_dn_s2  <= 1'b0;
         r_dn_db  <= 1'b0;
         r_dn_cnt <= '0;
      end else begin
         r_dn_s1 <= btn_down;
         r_dn_s2 <= r_dn_s1;
         if (r_dn_s2 == r_dn_db) begin
            r_dn_cnt <= '0;
         end else if (w_dn_flip) begin
            r_dn_db  <= r_dn_s2;
            r_dn_cnt <= '0;
         end else begin
            r_dn_cnt <= r_dn_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_press    <= 1'b0;
         r_pending  <= 1'b0;
         r_hold     <= '0;
         r_state    <= IDLE;
         io_jump    <= 1'b0;
         io_duck    <= 1'b0;
         jump_count <= 8'd0;
         drop_count <= 8'd0;
      end else begin
         r_press <= w_up_press;
         if (w_up_press) begin
            jump_count <= jump_count + 8'd1;
         end
         if (screen_end) begin
            io_duck <= r_dn_db;
         end

         // Consuming pending reloads it from the strobe so a coincident press survives.
         if (r_press) begin
            r_pending <= 1'b1;
         end

         case (r_state)
            IDLE: begin
               if (screen_end && r_pending) begin
                  r_state   <= PRESENT;
                  io_jump   <= 1'b1;
                  r_hold    <= '0;
                  r_pending <= r_press;
               end
            end
            PRESENT: begin
               if (io_ack) begin
                  if (screen_end && r_pending) begin
                     r_hold    <= '0;
                     r_pending <= r_press;
                  end else begin
                     r_state <= IDLE;
                     io_jump <= 1'b0;
                  end
               end else if (screen_end) begin
                  if (r_hold == c_hold_last) begin
                     r_state <= IDLE;
                     io_jump <= 1'b0;
                     if (drop_count != 8'hFF) begin
                        drop_count <= drop_count + 8'd1;
                     end
                  end else begin
                     r_hold <= r_hold + c_hold_w'(1);
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               io_jump <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dino_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dino_input_ctrl
// Description : Vector table plus directed sequences for dino_input_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dino_input_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic       btn_up, btn_down, screen_end, io_ack;
   logic       io_jump, io_duck;
   logic [7:0] jump_count, drop_count;

   int total = 0;
   int bad   = 0;

   dino_input_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W          (4),
      .HOLD_FRAMES    (2)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .screen_end(screen_end),
      .io_ack    (io_ack),
      .io_jump   (io_jump),
      .io_duck   (io_duck),
      .jump_count(jump_count),
      .drop_count(drop_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       up;
      logic       down;
      logic       se;
      logic       ack;
      logic       jump;
      logic       duck;
      logic [7:0] jc;
      logic [7:0] dc;
   } vec_t;

   vec_t vecs[$];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic add(input logic up, input logic down, input logic se, input logic ack,
                      input logic jump, input logic duck, input logic [7:0] jc,
                      input logic [7:0] dc);
      vec_t v;
      v.up = up; v.down = down; v.se = se; v.ack = ack;
      v.jump = jump; v.duck = duck; v.jc = jc; v.dc = dc;
      vecs.push_back(v);
   endtask

   task automatic do_reset();
      reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0; screen_end = 1'b0; io_ack = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
   endtask

   // One clean press: debounced rise 6 cycles in, fully released by the end.
   task automatic press();
      screen_end = 1'b0; io_ack = 1'b0;
      btn_up = 1'b1;
      repeat (8) tick();
      btn_up = 1'b0;
      repeat (8) tick();
   endtask

   task automatic frame();
      screen_end = 1'b1;
      tick();
      screen_end = 1'b0;
   endtask

   initial begin
      // Table: inputs applied before each edge, outputs expected after it.
      for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 0, 0, 0, 0);
      add(1, 1, 1, 0, 0, 0, 0, 0);
      add(1, 1, 0, 0, 0, 0, 0, 0);
      add(1, 1, 0, 0, 0, 0, 1, 0);
      add(1, 1, 0, 0, 0, 0, 1, 0);
      add(1, 1, 1, 0, 1, 1, 1, 0);
      for (int i = 0; i < 4; i++) add(1, 1, 0, 0, 1, 1, 1, 0);
      add(1, 1, 0, 1, 0, 1, 1, 0);
      add(1, 1, 0, 0, 0, 1, 1, 0);
      add(1, 1, 0, 1, 0, 1, 1, 0);
      for (int i = 0; i < 6; i++) add(0, 1, 0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 1, 1, 0);
      add(0, 1, 1, 0, 0, 1, 1, 0);
      for (int i = 0; i < 2; i++) add(0, 1, 0, 0, 0, 1, 1, 0);

      reset = 1'b1; btn_up = 1'b1; btn_down = 1'b0; screen_end = 1'b0; io_ack = 1'b0;
      repeat (3) tick();
      chk("rst_jump", io_jump, 0);
      chk("rst_duck", io_duck, 0);
      chk("rst_jc", jump_count, 0);
      chk("rst_dc", drop_count, 0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         btn_up = vecs[i].up; btn_down = vecs[i].down;
         screen_end = vecs[i].se; io_ack = vecs[i].ack;
         tick();
         chk($sformatf("vec%0d_jump", i), io_jump, vecs[i].jump);
         chk($sformatf("vec%0d_duck", i), io_duck, vecs[i].duck);
         chk($sformatf("vec%0d_jc", i), jump_count, vecs[i].jc);
         chk($sformatf("vec%0d_dc", i), drop_count, vecs[i].dc);
      end

      // Duck release only lands on a frame boundary.
      btn_up = 1'b0; btn_down = 1'b0; screen_end = 1'b0; io_ack = 1'b0;
      repeat (8) tick();
      chk("duck_hold", io_duck, 1);
      frame();
      chk("duck_fall", io_duck, 0);

      // Timeout after two frames of presentation.
      do_reset();
      press();
      chk("to_jc", jump_count, 1);
      chk("to_idle", io_jump, 0);
      frame();
      chk("to_present", io_jump, 1);
      frame();
      chk("to_hold1", io_jump, 1);
      frame();
      chk("to_drop_jump", io_jump, 0);
      chk("to_drop_dc", drop_count, 1);

      // Two merged presses give a single presentation.
      do_reset();
      press();
      press();
      chk("b2b_jc", jump_count, 2);
      frame();
      chk("b2b_present", io_jump, 1);
      io_ack = 1'b1; tick(); io_ack = 1'b0;
      chk("b2b_ack", io_jump, 0);
      frame();
      chk("b2b_single", io_jump, 0);

      // Ack coincident with frame end while another request is pending.
      press();
      frame();
      chk("chain_present", io_jump, 1);
      press();
      chk("chain_jc", jump_count, 4);
      frame();
      chk("chain_hold1", io_jump, 1);
      io_ack = 1'b1; screen_end = 1'b1; tick(); io_ack = 1'b0; screen_end = 1'b0;
      chk("chain_stay", io_jump, 1);
      chk("chain_nodrop", drop_count, 0);
      frame();
      chk("chain_restart", io_jump, 1);
      frame();
      chk("chain_expire", io_jump, 0);
      chk("chain_dc", drop_count, 1);

      // Same coincidence with nothing pending: ack wins, no drop.
      press();
      frame();
      io_ack = 1'b1; screen_end = 1'b1; tick(); io_ack = 1'b0; screen_end = 1'b0;
      chk("ackwin_jump", io_jump, 0);
      chk("ackwin_dc", drop_count, 1);

      // Press strobe on the very cycle pending is consumed.
      do_reset();
      press();
      btn_up = 1'b1;
      repeat (6) tick();
      frame();
      tick();
      btn_up = 1'b0;
      repeat (8) tick();
      chk("coin_jc", jump_count, 2);
      chk("coin_present", io_jump, 1);
      io_ack = 1'b1; tick(); io_ack = 1'b0;
      chk("coin_ack", io_jump, 0);
      frame();
      chk("coin_kept", io_jump, 1);

      // Reset mid-presentation discards the request.
      reset = 1'b1; tick(); reset = 1'b0;
      chk("midrst_jump", io_jump, 0);
      chk("midrst_jc", jump_count, 0);
      frame();
      chk("midrst_nopend", io_jump, 0);

      // Saturation of drop_count and wrap of jump_count.
      do_reset();
      for (int i = 0; i < 300; i++) begin
         press();
         frame();
         frame();
         frame();
      end
      chk("sat_dc", drop_count, 255);
      chk("sat_jc", jump_count, 44);

      do_reset();
      for (int i = 0; i < 257; i++) press();
      chk("wrap_jc", jump_count, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dino_input_ctrl.md
Name: dino_input_ctrl

Overview:
- Sits between the board push-buttons and the processor IO port, replacing the direct wiring of the raw `up` pin to `io_jump`.
- Synchronizes and debounces the `up` and `down` buttons.
- Turns each `up` press into one frame-aligned jump request, held until the processor acknowledges it.
- Presents a frame-coherent duck level for `down`, and keeps event counters for debug probes.

Parameters:
- DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles required to accept a new button level (10 ms at 100 MHz).
- CNT_W, default 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- HOLD_FRAMES, default 2: screen_end pulses an unacknowledged jump request survives before it is dropped.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- btn_up  input  1  raw, asynchronous jump button.
- btn_down  input  1  raw, asynchronous duck button.
- screen_end  input  1  one-cycle pulse at end of each VGA frame (60 Hz).
- io_ack  input  1  one-cycle pulse from processor: jump request consumed.
- io_jump  output  1  jump request to processor.
- io_duck  output  1  debounced down level, frame-coherent.
- jump_count  output  8  accepted presses, wraps modulo 256.
- drop_count  output  8  requests expired without ack, saturates at 255.

Behaviour:
- Reset: on a clock edge with reset=1, all state clears. This includes synchronizers, debounced levels, debounce counters, pending, io_jump, io_duck, the hold counter, jump_count and drop_count, all to 0. Reset asserted mid-operation discards any pending or presented request.
- Synchronizer: each button passes through 2 flops before any other logic.
- Debounce (per button, independent):
  - Counter resets to 0 whenever the synced level equals the debounced level.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the levels still differ, the debounced level takes the synced level and the counter resets.
  - A glitch shorter than DEBOUNCE_CYCLES is ignored.
  - Minimum latency from a raw change to the debounced change is DEBOUNCE_CYCLES+2 cycles.
- Press event: a 0->1 transition of debounced up, as a single-cycle strobe. jump_count increments on the same edge the strobe is registered.
- Pending flag (single-depth): set by a press event. Further presses while pending is already set are merged: pending stays 1, but jump_count still counts them.
- Request state machine, states IDLE and PRESENT:
  - IDLE, io_jump=0: on screen_end with pending=1, go to PRESENT next cycle. io_jump=1, pending clears, hold counter=0.
  - PRESENT, io_jump=1, on io_ack: go to IDLE and set io_jump=0.
  - PRESENT, on screen_end without ack: hold counter increments. When the counter would reach HOLD_FRAMES, go to IDLE, set io_jump=0 and increment drop_count (saturating).
  - Simultaneous io_ack and screen_end in PRESENT with pending=1: the ack retires the current request and the next is presented immediately. State stays PRESENT, io_jump stays 1, hold counter=0, pending clears.
  - Same case with pending=0: the ack wins, go to IDLE, no drop.
  - A press event in the same cycle that pending is consumed re-sets pending; no event is lost.
  - io_ack in IDLE is ignored.
- Duck: io_duck loads the debounced down level only on cycles where screen_end=1, and holds otherwise.
- Counters: jump_count wraps from 255 to 0. drop_count holds at 255.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_FRAMES=2, screen_end pulsed every 20 cycles):
1. Reset behaviour: hold reset 3 cycles with btn_up=1 -> all outputs 0. After release, debounced up rises 6 cycles later and jump_count=1. io_jump rises on the cycle after the next screen_end.
2. Glitch rejection: btn_up high for 3 cycles, then low -> jump_count stays 0 and io_jump never asserts.
3. Ack path: after one press, pulse io_ack 5 cycles after io_jump rises -> io_jump=0 on the next cycle and drop_count=0.
4. Timeout: one press with no ack -> io_jump falls after the 2nd screen_end following presentation. drop_count=1.
5. Back-to-back presses: two presses 12 cycles apart before the first screen_end -> jump_count=2, a single presentation. A third press while presenting, then ack coincident with screen_end -> io_jump stays 1 continuously and the hold counter restarts.
6. Duck and saturation: btn_down held -> io_duck rises only at a screen_end edge. Force 300 timeouts -> drop_count=255. Force 257 presses -> jump_count=1.
